// File: rtl/tdc_spi_reg_seq.sv
// Register-transaction sequencer for the TDC SPI byte master.
// Sends a command byte and 1..3 data bytes, collects read data, and guards each byte with a watchdog.
module tdc_spi_reg_seq #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        wr,
    input  logic [5:0]  addr,
    input  logic [1:0]  nbytes,
    input  logic [23:0] wdata,
    output logic [23:0] rdata,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic        spi_start,
    output logic [7:0]  spi_data_in,
    output logic        spi_cs_end,
    input  logic [7:0]  spi_data_out,
    input  logic        spi_busy,
    input  logic        spi_new_data
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, START, WAIT, FINISH} state_t;

    state_t        state, state_nx;
    logic          wr_q;
    logic [1:0]    n_q;
    logic [23:0]   wdata_q;
    logic [23:0]   shift_q;
    logic [1:0]    byte_idx;
    logic [CW-1:0] tmo;
    logic [1:0]    n_in;
    logic [1:0]    sel;
    logic [7:0]    wbyte;
    logic          tmo_hit;
    logic          last_byte;
    logic          abort;

    assign n_in      = (nbytes == 2'd0) ? 2'd1 : nbytes;
    assign tmo_hit   = (tmo == CW'(TIMEOUT - 1));
    assign last_byte = (byte_idx == n_q);
    assign abort     = (state == WAIT) && !spi_new_data && tmo_hit;

    // Data bytes go out MSB byte first, so byte k picks lane n-1-k.
    assign sel = n_q - 2'd1 - byte_idx;

    always_comb begin
        wbyte = 8'h00;
        unique case (sel)
            2'd0:    wbyte = wdata_q[7:0];
            2'd1:    wbyte = wdata_q[15:8];
            2'd2:    wbyte = wdata_q[23:16];
            default: wbyte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:   if (req) state_nx = START;
            START:  if (!spi_busy) state_nx = WAIT;
            WAIT: begin
                if (spi_new_data) state_nx = last_byte ? FINISH : START;
                else if (tmo_hit) state_nx = IDLE;
            end
            FINISH: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        spi_start = (state == START) && !spi_busy;
        done      = (state == FINISH) || abort;
        err       = abort;
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q        <= 1'b0;
            n_q         <= 2'd0;
            wdata_q     <= '0;
            shift_q     <= '0;
            byte_idx    <= 2'd0;
            tmo         <= '0;
            rdata       <= '0;
            spi_data_in <= 8'h00;
            spi_cs_end  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (req) begin
                    wr_q        <= wr;
                    n_q         <= n_in;
                    wdata_q     <= wdata;
                    shift_q     <= '0;
                    byte_idx    <= 2'd0;
                    spi_data_in <= {n_in > 2'd1, wr, addr};
                    spi_cs_end  <= 1'b0;
                end
                START: if (spi_start) tmo <= '0;
                WAIT: begin
                    tmo <= tmo + CW'(1);
                    if (spi_new_data) begin
                        if (byte_idx != 2'd0 && !wr_q)
                            shift_q <= {shift_q[15:0], spi_data_out};
                        if (!last_byte) begin
                            byte_idx    <= byte_idx + 2'd1;
                            spi_data_in <= wr_q ? wbyte : 8'h00;
                            spi_cs_end  <= (byte_idx == n_q - 2'd1);
                        end
                    end
                end
                FINISH: if (!wr_q) rdata <= shift_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_spi_reg_seq.sv
// Directed bench for tdc_spi_reg_seq with a behavioural SPI byte master.
// Covers reads, writes, watchdog abort, held req, mid-run reset and start back-pressure.
module tb_tdc_spi_reg_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [5:0]  addr = '0;
    logic [1:0]  nbytes = '0;
    logic [23:0] wdata = '0;
    logic [23:0] rdata;
    logic        done, err, busy;
    logic        spi_start;
    logic [7:0]  spi_data_in;
    logic        spi_cs_end;
    logic [7:0]  spi_data_out = 8'h00;
    logic        spi_busy;
    logic        spi_new_data = 1'b0;

    logic        m_busy = 1'b0;
    logic        hold_busy = 1'b0;
    logic        mute = 1'b0;
    int          cnt = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          start_cnt = 0;
    int          dbl_start = 0;
    int          done_cnt = 0;
    logic        prev_start = 1'b0;
    logic [7:0]  miso_q[$];
    logic [7:0]  mosi_q[$];
    logic        cse_q[$];

    int checks = 0;
    int failures = 0;

    assign spi_busy = m_busy | hold_busy;

    tdc_spi_reg_seq #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .addr(addr),
        .nbytes(nbytes), .wdata(wdata), .rdata(rdata), .done(done),
        .err(err), .busy(busy), .spi_start(spi_start),
        .spi_data_in(spi_data_in), .spi_cs_end(spi_cs_end),
        .spi_data_out(spi_data_out), .spi_busy(spi_busy),
        .spi_new_data(spi_new_data)
    );

    always #5 clk = ~clk;

    // Byte master model: 3-cycle byte time, then a new_data pulse.
    always @(posedge clk) begin
        cyc          <= cyc + 1;
        spi_new_data <= 1'b0;
        prev_start   <= spi_start;
        if (spi_start && prev_start) dbl_start <= dbl_start + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (spi_start) begin
            mosi_q.push_back(spi_data_in);
            cse_q.push_back(spi_cs_end);
            start_cyc <= cyc;
            start_cnt <= start_cnt + 1;
            m_busy    <= 1'b1;
            cnt       <= 3;
        end else if (m_busy) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                m_busy <= 1'b0;
                if (!mute) begin
                    spi_new_data <= 1'b1;
                    spi_data_out <= (miso_q.size() > 0) ? miso_q.pop_front() : 8'hEE;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output bit ok, output bit e, output int dcyc);
        ok = 0; e = 0; dcyc = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (done) begin
                ok = 1; e = err; dcyc = cyc;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic run(input logic w, input logic [5:0] a, input logic [1:0] n,
                       input logic [23:0] d, output bit ok, output bit e, output int dcyc);
        @(negedge clk);
        mosi_q.delete(); cse_q.delete();
        wr = w; addr = a; nbytes = n; wdata = d; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        wait_done(ok, e, dcyc);
    endtask

    function automatic logic [31:0] mosi_at(input int i);
        return (i < mosi_q.size()) ? {24'h0, mosi_q[i]} : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] cse_bits();
        logic [31:0] v = '0;
        foreach (cse_q[i]) v = {v[30:0], cse_q[i]};
        return v;
    endfunction

    initial begin
        bit ok, e;
        int dcyc, sc, dc;

        // Reset state
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_start", spi_start, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_din", spi_data_in, 0);
        chk("rst_csend", spi_cs_end, 0);
        @(negedge clk); rst_n = 1'b1;

        // 1: read addr 01, one byte
        miso_q = '{8'hFF, 8'hA5};
        run(1'b0, 6'h01, 2'd1, 24'h0, ok, e, dcyc);
        chk("t1_done", ok, 1);
        chk("t1_err", e, 0);
        chk("t1_nbytes", mosi_q.size(), 2);
        chk("t1_cmd", mosi_at(0), 32'h01);
        chk("t1_b1", mosi_at(1), 32'h00);
        chk("t1_cse", cse_bits(), 32'b01);
        @(negedge clk);
        chk("t1_rdata", rdata, 24'h0000A5);
        chk("t1_busy_low", busy, 0);
        chk("t1_done_1cyc", done, 0);

        // 2: read addr 10, three bytes
        miso_q = '{8'hFF, 8'h12, 8'h34, 8'h56};
        run(1'b0, 6'h10, 2'd3, 24'h0, ok, e, dcyc);
        chk("t2_done", ok, 1);
        chk("t2_err", e, 0);
        chk("t2_cmd", mosi_at(0), 32'h90);
        chk("t2_nbytes", mosi_q.size(), 4);
        chk("t2_cse", cse_bits(), 32'b0001);
        @(negedge clk);
        chk("t2_rdata", rdata, 24'h123456);

        // 3: write addr 00, one byte
        miso_q = '{8'hFF, 8'hFF};
        run(1'b1, 6'h00, 2'd1, 24'h000043, ok, e, dcyc);
        chk("t3_done", ok, 1);
        chk("t3_err", e, 0);
        chk("t3_cmd", mosi_at(0), 32'h40);
        chk("t3_b1", mosi_at(1), 32'h43);
        @(negedge clk);
        chk("t3_rdata_kept", rdata, 24'h123456);

        // 4: byte master never answers
        mute = 1'b1;
        run(1'b0, 6'h05, 2'd1, 24'h0, ok, e, dcyc);
        chk("t4_done", ok, 1);
        chk("t4_err", e, 1);
        chk("t4_delay", dcyc - start_cyc, 16);
        @(negedge clk);
        chk("t4_busy_low", busy, 0);
        chk("t4_rdata_kept", rdata, 24'h123456);
        mute = 1'b0;
        repeat (4) @(negedge clk);

        // 5: req held high, nbytes=0, then reset mid-run
        mosi_q.delete(); cse_q.delete();
        miso_q = '{8'hFF, 8'h77, 8'hFF, 8'h88};
        wr = 1'b0; addr = 6'h02; nbytes = 2'd0; req = 1'b1;
        @(negedge clk);
        wait_done(ok, e, dcyc);
        chk("t5_done", ok, 1);
        chk("t5_nbytes", mosi_q.size(), 2);
        chk("t5_cmd", mosi_at(0), 32'h02);
        chk("t5_cse", cse_bits(), 32'b01);
        @(negedge clk);
        chk("t5_gap", busy, 0);
        chk("t5_rdata", rdata, 24'h000077);
        @(negedge clk);
        chk("t5_reaccept", busy, 1);
        for (int i = 0; i < 50 && mosi_q.size() < 3; i++) @(negedge clk);
        chk("t5_second_cmd", mosi_at(2), 32'h02);
        dc = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_start", spi_start, 0);
        chk("t5_rst_done", done, 0);
        req = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_no_done", done_cnt, dc);
        chk("t5_rst_rdata", rdata, 0);
        rst_n = 1'b1;
        m_busy = 1'b0;
        @(negedge clk);

        // 6: start held off by spi_busy for 5 cycles
        mosi_q.delete(); cse_q.delete();
        miso_q = '{8'hFF, 8'hFF, 8'hFF};
        sc = start_cnt;
        hold_busy = 1'b1;
        wr = 1'b1; addr = 6'h03; nbytes = 2'd2; wdata = 24'h00BEEF; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (5) @(negedge clk);
        chk("t6_held", start_cnt - sc, 0);
        chk("t6_busy", busy, 1);
        hold_busy = 1'b0;
        wait_done(ok, e, dcyc);
        chk("t6_done", ok, 1);
        chk("t6_err", e, 0);
        chk("t6_starts", start_cnt - sc, 3);
        chk("t6_cmd", mosi_at(0), 32'hC3);
        chk("t6_b1", mosi_at(1), 32'hBE);
        chk("t6_b2", mosi_at(2), 32'hEF);
        chk("t6_cse", cse_bits(), 32'b001);
        chk("t6_single_pulse", dbl_start, 0);
        @(negedge clk);
        chk("t6_rdata_kept", rdata, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
